// File: rtl/mul_sequencer_pkg.sv
// Shared constants for the multiply sequencer and the execute-stage ALU it borrows.
package mul_sequencer_pkg;

    // ALU control encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions inside the 4-bit NZCV flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_sequencer_alu.sv
// Execute-stage ALU: add/sub/and/or with NZCV flags. Lives beside the
// sequencer; the sequencer only borrows its add path.
module mul_sequencer_alu
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH:0] sum;

    // Operation select; carry follows ARM convention (C = NOT borrow on subtract)
    always_comb begin
        sum   = '0;
        flags = '0;
        case (ctrl)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: sum = {1'b0, a & b};
            default: sum = {1'b0, a | b};
        endcase
        result        = sum[WIDTH-1:0];
        flags[FLAG_N] = sum[WIDTH-1];
        flags[FLAG_Z] = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/mul_sequencer.sv
// MUL/MLA sequencer: iterative shift-add on the shared ALU add path.
// Owns the ALU and stalls the pipeline while busy; passes the pipeline's
// ALU request straight through while idle.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_mla,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] pipe_a,
    input  logic [WIDTH-1:0] pipe_b,
    input  logic [1:0]       pipe_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       nz
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] acc_nxt, mplier_sh, acc_init;
    logic             iter_last;

    function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], v == '0};
    endfunction

    // Per-iteration next values; the add result is only taken on a set multiplier bit
    always_comb begin
        acc_nxt   = mplier[0] ? alu_result : acc;
        mplier_sh = mplier >> 1;
        iter_last = (EARLY_TERM && (mplier_sh == '0)) || (cnt == CNT_LAST);
        acc_init  = is_mla ? rn : '0;
    end

    // ALU ownership: accumulate during ITER, pipeline pass-through otherwise
    always_comb begin
        alu_a    = pipe_a;
        alu_b    = pipe_b;
        alu_ctrl = pipe_ctrl;
        if (state == ITER) begin
            alu_a    = acc;
            alu_b    = mcand;
            alu_ctrl = ALU_ADD;
        end
    end

    // Sequencer FSM with registered busy/done/result/nz
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            nz     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= acc_init;
                        mcand  <= rm;
                        mplier <= rs;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (rs == '0) begin
                            // nothing to add: the product is just the accumulate term
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= acc_init;
                            nz     <= nz_of(acc_init);
                        end else begin
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_sh;
                    cnt    <= cnt + 1'b1;
                    if (iter_last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= acc_nxt;
                        nz     <= nz_of(acc_nxt);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench: two sequencers (early-terminate on/off), each looped
// through its own ALU, checked against an arithmetic reference model.
module tb_mul_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_et = 1'b0, start_nt = 1'b0;
    logic          is_mla = 1'b0;
    logic [W-1:0]  rm = '0, rs = '0, rn = '0;
    logic [W-1:0]  pipe_a = '0, pipe_b = '0;
    logic [1:0]    pipe_ctrl = 2'b00;

    logic [W-1:0]  alu_a_et, alu_b_et, alu_res_et, result_et;
    logic [1:0]    alu_ctrl_et, nz_et;
    logic [3:0]    flags_et;
    logic          busy_et, done_et;

    logic [W-1:0]  alu_a_nt, alu_b_nt, alu_res_nt, result_nt;
    logic [1:0]    alu_ctrl_nt, nz_nt;
    logic [3:0]    flags_nt;
    logic          busy_nt, done_nt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b1)) dut_et (
        .clk(clk), .reset(reset), .start(start_et), .is_mla(is_mla),
        .rm(rm), .rs(rs), .rn(rn),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_ctrl(pipe_ctrl),
        .alu_a(alu_a_et), .alu_b(alu_b_et), .alu_ctrl(alu_ctrl_et),
        .alu_result(alu_res_et), .busy(busy_et), .done(done_et),
        .result(result_et), .nz(nz_et)
    );
    mul_sequencer_alu #(.WIDTH(W)) alu_et (
        .a(alu_a_et), .b(alu_b_et), .ctrl(alu_ctrl_et), .result(alu_res_et), .flags(flags_et)
    );

    mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .start(start_nt), .is_mla(is_mla),
        .rm(rm), .rs(rs), .rn(rn),
        .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_ctrl(pipe_ctrl),
        .alu_a(alu_a_nt), .alu_b(alu_b_nt), .alu_ctrl(alu_ctrl_nt),
        .alu_result(alu_res_nt), .busy(busy_nt), .done(done_nt),
        .result(result_nt), .nz(nz_nt)
    );
    mul_sequencer_alu #(.WIDTH(W)) alu_nt (
        .a(alu_a_nt), .b(alu_b_nt), .ctrl(alu_ctrl_nt), .result(alu_res_nt), .flags(flags_nt)
    );

    // Reference: iteration count from the multiplier's highest set bit
    function automatic int exp_k(input logic [W-1:0] m, input bit et);
        if (m == '0) return 0;
        if (!et) return W;
        for (int i = W - 1; i >= 0; i--) if (m[i]) return i + 1;
        return 0;
    endfunction

    // Reference: product plus optional accumulate, truncated to W bits
    function automatic logic [W-1:0] exp_prod(input bit mla, input logic [W-1:0] a, b, c);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b} + (mla ? {{W{1'b0}}, c} : '0);
        return p[W-1:0];
    endfunction

    // Runs one op from cycle 0 (caller is just past a negedge) to cycle k+2
    task automatic do_op(input string nm, input bit nt, input bit mla,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        int k;
        logic [W-1:0] er;
        logic bz, dn;
        logic [W-1:0] r;
        logic [1:0] z;
        k  = exp_k(b, !nt);
        er = exp_prod(mla, a, b, c);
        is_mla = mla; rm = a; rs = b; rn = c;
        if (nt) start_nt = 1'b1; else start_et = 1'b1;
        #1;
        bz = nt ? busy_nt : busy_et;
        n_cmp++;
        if (bz !== 1'b0) begin
            n_bad++; $display("FAIL %s busy@0: got %b want 0", nm, bz);
        end
        for (int cyc = 1; cyc <= k + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_et = 1'b0; start_nt = 1'b0;
                rm = $urandom; rs = $urandom; rn = $urandom; is_mla = 1'($urandom);
            end
            bz = nt ? busy_nt : busy_et;
            dn = nt ? done_nt : done_et;
            r  = nt ? result_nt : result_et;
            z  = nt ? nz_nt : nz_et;
            n_cmp++;
            if (bz !== (cyc <= k + 1)) begin
                n_bad++; $display("FAIL %s busy@%0d: got %b want %b", nm, cyc, bz, cyc <= k + 1);
            end
            n_cmp++;
            if (dn !== (cyc == k + 1)) begin
                n_bad++; $display("FAIL %s done@%0d: got %b want %b", nm, cyc, dn, cyc == k + 1);
            end
            if (cyc == k + 1) begin
                n_cmp++;
                if (r !== er) begin
                    n_bad++; $display("FAIL %s result: got %h want %h", nm, r, er);
                end
                n_cmp++;
                if (z !== {er[W-1], er == '0}) begin
                    n_bad++; $display("FAIL %s nz: got %b want %b", nm, z, {er[W-1], er == '0});
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy_et, done_et, result_et, nz_et} !== '0) begin
            n_bad++; $display("FAIL reset_et: got b%b d%b r%h nz%b want zeros", busy_et, done_et, result_et, nz_et);
        end
        n_cmp++;
        if ({busy_nt, done_nt, result_nt, nz_nt} !== '0) begin
            n_bad++; $display("FAIL reset_nt: got b%b d%b r%h nz%b want zeros", busy_nt, done_nt, result_nt, nz_nt);
        end
    endtask

    task automatic test_passthrough();
        pipe_ctrl = 2'b01; pipe_a = 32'd9; pipe_b = 32'd4;
        #1;
        n_cmp++;
        if ({alu_a_et, alu_b_et, alu_ctrl_et} !== {32'd9, 32'd4, 2'b01}) begin
            n_bad++; $display("FAIL pass_ports: got %h %h %b want 9 4 01", alu_a_et, alu_b_et, alu_ctrl_et);
        end
        n_cmp++;
        if (alu_res_et !== 32'd5 || flags_et !== 4'b0010) begin
            n_bad++; $display("FAIL pass_alu: got %h/%b want 5/0010", alu_res_et, flags_et);
        end
        n_cmp++;
        if (alu_res_nt !== 32'd5 || flags_nt !== 4'b0010) begin
            n_bad++; $display("FAIL pass_alu_nt: got %h/%b want 5/0010", alu_res_nt, flags_nt);
        end
        pipe_ctrl = 2'b00; pipe_a = '0; pipe_b = '0;
    endtask

    task automatic test_directed();
        do_op("mul3x5", 1'b0, 1'b0, 32'd3, 32'd5, 32'd0);
        do_op("mla_rs0", 1'b0, 1'b1, 32'd7, 32'd0, 32'd100);
        do_op("mul_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("nt_rs1", 1'b1, 1'b0, 32'h1234_5678, 32'd1, 32'd0);
        do_op("mul_2p32", 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0);
        do_op("mla_neg", 1'b0, 1'b1, 32'd2, 32'd3, 32'hFFFF_FFF0);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_a", 1'b0, 1'b1, 32'd11, 32'd13, 32'd1);
        do_op("b2b_b", 1'b0, 1'b0, 32'd6, 32'd2, 32'd0);
        do_op("b2b_nt", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h8000_0001, 32'd5);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, c;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; c = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = '0;
            do_op("rand", (i % 4) == 3, 1'($urandom), a, b, c);
        end
    endtask

    task automatic test_ignored_start();
        int dones;
        dones = 0;
        is_mla = 1'b0; rm = 32'd3; rs = 32'd5; rn = '0; start_et = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start_et = (cyc == 2 || cyc == 3);
            rm = 32'd100; rs = 32'd1;
            if (done_et) dones++;
        end
        start_et = 1'b0;
        n_cmp++;
        if (dones != 1) begin
            n_bad++; $display("FAIL ignored_start dones: got %0d want 1", dones);
        end
        n_cmp++;
        if (result_et !== 32'd15) begin
            n_bad++; $display("FAIL ignored_start result: got %h want f", result_et);
        end
    endtask

    task automatic test_reset_mid();
        is_mla = 1'b0; rm = 32'hFFFF_FFFF; rs = 32'hFFFF_FFFF; start_et = 1'b1;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            start_et = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pipe_ctrl = 2'b11; pipe_a = 32'h0F0; pipe_b = 32'h00F;
        #1;
        n_cmp++;
        if ({busy_et, done_et, result_et, nz_et} !== '0) begin
            n_bad++; $display("FAIL reset_mid state: got b%b d%b r%h nz%b want zeros", busy_et, done_et, result_et, nz_et);
        end
        n_cmp++;
        if (alu_ctrl_et !== 2'b11 || alu_res_et !== 32'h0FF) begin
            n_bad++; $display("FAIL reset_mid pass: got %b/%h want 11/ff", alu_ctrl_et, alu_res_et);
        end
        pipe_ctrl = 2'b00; pipe_a = '0; pipe_b = '0;
        do_op("after_reset", 1'b0, 1'b0, 32'd3, 32'd5, 32'd0);
    endtask

    task automatic test_start_with_reset();
        reset = 1'b1; start_et = 1'b1; rm = 32'd4; rs = 32'd4;
        @(negedge clk);
        reset = 1'b0; start_et = 1'b0;
        n_cmp++;
        if (busy_et !== 1'b0) begin
            n_bad++; $display("FAIL start_with_reset busy: got %b want 0", busy_et);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed();
        test_back_to_back();
        test_ignored_start();
        test_random();
        test_reset_mid();
        test_start_with_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
